parc_mem_req_arb: RTL and testbench
===================================

Name: parc_mem_req_arb

Overview:
Parametrised N-port memory request arbiter with in-order response routing. It lets several val/rdy requesters (imem and dmem ports of one or more PARCv2 cores, or DMA/host ports) share a single memory request/response port. Requests are multiplexed by round-robin or fixed-priority arbitration. A tag FIFO records the granting port of every outstanding request, so in-order memory responses are steered back to the correct requester. Sits between the core top-level memory ports and the test memory / cache.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
REQ_SZ, 67, request message width in bits (VC_MEM_REQ_MSG_SZ(32,32))
RESP_SZ, 35, response message width in bits (VC_MEM_RESP_MSG_SZ(32))
MAX_OUTSTANDING, 4, tag FIFO depth; maximum number of in-flight requests (power of two, >=1)
PRIORITY_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 highest

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low (asserted when 0)
in_req_msg  in  NUM_PORTS*REQ_SZ  per-port request message; port i occupies bits [i*REQ_SZ +: REQ_SZ]
in_req_val  in  NUM_PORTS  per-port request valid
in_req_rdy  out  NUM_PORTS  per-port request ready
in_resp_msg  out  NUM_PORTS*RESP_SZ  per-port response message; every slice equals out_resp_msg
in_resp_val  out  NUM_PORTS  per-port response valid; one-hot or zero
out_req_msg  out  REQ_SZ  request message sent to memory
out_req_val  out  1  request valid to memory
out_req_rdy  in  1  memory request ready
out_resp_msg  in  RESP_SZ  response message from memory
out_resp_val  in  1  response valid from memory; no back-pressure
outstanding  out  clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
err_orphan_resp  out  1  sticky flag: a response arrived while no request was outstanding

Behaviour:
- Request path is combinational, with zero-cycle pass-through.
  - full = (outstanding == MAX_OUTSTANDING).
  - Grant g = the first valid port at or after rr_ptr in round-robin mode, or the lowest-index valid port in fixed-priority mode.
  - out_req_val = |in_req_val & !full.
  - out_req_msg = slice g. When no port is valid, out_req_msg = slice 0.
  - in_req_rdy[i] = out_req_rdy & !full & (i == g) & in_req_val[i]. At most one bit is high.
- A request fires when out_req_val & out_req_rdy are both high. On fire, g is pushed into the tag FIFO at the tail.
  - Round-robin mode: rr_ptr <= (g+1) mod NUM_PORTS, updated only on fire. A stalled grant does not rotate.
  - Fixed-priority mode: rr_ptr is unused and stays 0.
- Response path is combinational.
  - in_resp_val[i] = out_resp_val & !empty & (tag_head == i). The FIFO pops on the same edge.
  - Responses are assumed in order. Memory must not return more responses than requests.
- Orphan response: out_resp_val while empty. The response is dropped, all in_resp_val stay 0, and err_orphan_resp is set to 1 until reset.
- Simultaneous fire and pop: the push and pop both occur. outstanding is unchanged, and the FIFO stays correctly ordered, including when the pointers wrap.
- Full: out_req_val = 0 and all in_req_rdy = 0, even if a pop happens in the same cycle. There is no combinational path from out_resp_val to the ready signals.
- Wrap-around: head and tail pointers wrap modulo MAX_OUTSTANDING. outstanding is tracked separately, so full and empty are unambiguous.
- Reset asserted (reset == 0):
  - Effects take hold immediately, asynchronously.
  - rr_ptr = 0, FIFO empty, outstanding = 0, err_orphan_resp = 0.
  - out_req_val, all in_req_rdy and all in_resp_val are forced to 0 for as long as reset is low.
- Reset mid-operation: all in-flight tags are discarded. Responses that arrive after reset deasserts are orphans and set err_orphan_resp.
- NUM_PORTS == 1 degenerates to a pass-through plus the outstanding limit.

Test Plan:
1. NUM_PORTS=2, round-robin; both ports hold val with addresses 0x100 (port 0) and 0x200 (port 1); out_req_rdy=1 -> grants alternate 0,1,0,1; responses with data 0xA,0xB,0xC,0xD are delivered to ports 0,1,0,1 in that order.
2. MAX_OUTSTANDING=4; issue 4 requests with no responses -> outstanding=4, out_req_val=0 and in_req_rdy=0 on the 5th cycle; one response returns -> outstanding=3 and issue resumes on the next cycle.
3. Same-cycle fire and response at outstanding=2, repeated for 10 cycles -> outstanding stays 2; tags route correctly across several pointer wraps.
4. PRIORITY_MODE=1, NUM_PORTS=3; ports 0 and 2 held valid -> port 0 is always granted and port 2 starves; drop port 0 val -> port 2 is granted in the same cycle.
5. out_req_rdy=0 for 3 cycles while ports 0 and 1 are valid -> grant stays on port 0, rr_ptr unchanged; on ready, port 0 fires, then port 1.
6. Assert reset with 3 outstanding, release, then send one response -> outstanding=0, all in_resp_val=0, err_orphan_resp=1.

Source files
------------

// File: rtl/parc_mem_req_arb_if.sv
// Request/response bundle between N requesters and one memory port.
// slave = arbiter view, master = requesters plus memory (testbench view).
interface parc_mem_req_arb_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned REQ_SZ    = 67,
    parameter int unsigned RESP_SZ   = 35
);
    logic [NUM_PORTS*REQ_SZ-1:0]  in_req_msg;
    logic [NUM_PORTS-1:0]         in_req_val;
    logic [NUM_PORTS-1:0]         in_req_rdy;
    logic [NUM_PORTS*RESP_SZ-1:0] in_resp_msg;
    logic [NUM_PORTS-1:0]         in_resp_val;
    logic [REQ_SZ-1:0]            out_req_msg;
    logic                         out_req_val;
    logic                         out_req_rdy;
    logic [RESP_SZ-1:0]           out_resp_msg;
    logic                         out_resp_val;

    modport master (
        output in_req_msg, in_req_val, out_req_rdy, out_resp_msg, out_resp_val,
        input  in_req_rdy, in_resp_msg, in_resp_val, out_req_msg, out_req_val
    );

    modport slave (
        input  in_req_msg, in_req_val, out_req_rdy, out_resp_msg, out_resp_val,
        output in_req_rdy, in_resp_msg, in_resp_val, out_req_msg, out_req_val
    );
endinterface

// File: rtl/parc_mem_req_arb.sv
// N-port memory request arbiter (round-robin or fixed priority) with a tag FIFO
// that steers in-order memory responses back to the port that issued each request.
module parc_mem_req_arb #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned REQ_SZ          = 67,
    parameter int unsigned RESP_SZ         = 35,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned PRIORITY_MODE   = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    parc_mem_req_arb_if.slave                  bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_orphan_resp_o
);
    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CntW-1:0] MaxCnt   = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [IdxW-1:0] LastPort = IdxW'(NUM_PORTS - 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] tag_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            full, empty, fire, pop, found;
    logic [IdxW-1:0] gnt, cand;
    int unsigned     base;

    assign full  = (cnt_q == MaxCnt);
    assign empty = (cnt_q == '0);

    // Scan from the rotating pointer (or from port 0) for the first valid requester.
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        base  = (PRIORITY_MODE == 0) ? int'(rr_ptr_q) : 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = IdxW'((base + k) % NUM_PORTS);
            if (!found && bus.in_req_val[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        bus.out_req_msg = bus.in_req_msg[REQ_SZ-1:0];
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt == IdxW'(i)) bus.out_req_msg = bus.in_req_msg[i*REQ_SZ +: REQ_SZ];
        end
    end

    assign bus.out_req_val = rst_ni & (|bus.in_req_val) & !full;
    assign fire            = bus.out_req_val & bus.out_req_rdy;
    assign pop             = rst_ni & bus.out_resp_val & !empty;
    assign bus.in_resp_msg = {NUM_PORTS{bus.out_resp_msg}};

    always_comb begin
        bus.in_req_rdy  = '0;
        bus.in_resp_val = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.in_req_rdy[i]  = rst_ni & bus.out_req_rdy & !full & (gnt == IdxW'(i))
                                 & bus.in_req_val[i];
            bus.in_resp_val[i] = pop & (tag_q[head_q] == IdxW'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        err_d    = err_q | (bus.out_resp_val & empty);
        if (fire) begin
            tail_d = (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
            if (PRIORITY_MODE == 0) rr_ptr_d = (gnt == LastPort) ? '0 : gnt + 1'b1;
        end
        if (pop) head_d = (head_q == LastPtr) ? '0 : head_q + 1'b1;
        case ({fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            if (fire) tag_q[tail_q] <= gnt;
        end
    end

    assign outstanding_o     = cnt_q;
    assign err_orphan_resp_o = err_q;
endmodule

// File: tb/tb_parc_mem_req_arb.sv
// Two arbiter instances (2-port round-robin, 3-port fixed priority) checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_parc_mem_req_arb;
    localparam int unsigned REQ_SZ  = 67;
    localparam int unsigned RESP_SZ = 35;
    localparam int unsigned MAXO    = 4;
    localparam int unsigned MAXP    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    parc_mem_req_arb_if #(.NUM_PORTS(2), .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ)) bus_a ();
    parc_mem_req_arb_if #(.NUM_PORTS(3), .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ)) bus_b ();

    logic [2:0] cnt_a, cnt_b;
    logic       err_a, err_b;

    parc_mem_req_arb #(
        .NUM_PORTS(2), .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ),
        .MAX_OUTSTANDING(MAXO), .PRIORITY_MODE(0)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a),
        .outstanding_o(cnt_a), .err_orphan_resp_o(err_a)
    );

    parc_mem_req_arb #(
        .NUM_PORTS(3), .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ),
        .MAX_OUTSTANDING(MAXO), .PRIORITY_MODE(1)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b),
        .outstanding_o(cnt_b), .err_orphan_resp_o(err_b)
    );

    // Stimulus per DUT (index 0 = A, 1 = B), padded to the widest instance.
    logic [MAXP*REQ_SZ-1:0] rmsg [2];
    logic [MAXP-1:0]        rval [2];
    logic                   ordy [2];
    logic                   rspv [2];
    logic [RESP_SZ-1:0]     rspm [2];

    assign bus_a.in_req_msg   = rmsg[0][2*REQ_SZ-1:0];
    assign bus_a.in_req_val   = rval[0][1:0];
    assign bus_a.out_req_rdy  = ordy[0];
    assign bus_a.out_resp_msg = rspm[0];
    assign bus_a.out_resp_val = rspv[0];
    assign bus_b.in_req_msg   = rmsg[1];
    assign bus_b.in_req_val   = rval[1];
    assign bus_b.out_req_rdy  = ordy[1];
    assign bus_b.out_resp_msg = rspm[1];
    assign bus_b.out_resp_val = rspv[1];

    logic [MAXP-1:0]         o_rdy [2];
    logic [MAXP-1:0]         o_rv  [2];
    logic [MAXP*RESP_SZ-1:0] o_rm  [2];
    logic [REQ_SZ-1:0]       o_qm  [2];
    logic                    o_qv  [2];
    logic [2:0]              o_cnt [2];
    logic                    o_err [2];

    assign o_rdy[0] = {1'b0, bus_a.in_req_rdy};
    assign o_rv[0]  = {1'b0, bus_a.in_resp_val};
    assign o_rm[0]  = {{RESP_SZ{1'b0}}, bus_a.in_resp_msg};
    assign o_qm[0]  = bus_a.out_req_msg;
    assign o_qv[0]  = bus_a.out_req_val;
    assign o_cnt[0] = cnt_a;
    assign o_err[0] = err_a;
    assign o_rdy[1] = bus_b.in_req_rdy;
    assign o_rv[1]  = bus_b.in_resp_val;
    assign o_rm[1]  = bus_b.in_resp_msg;
    assign o_qm[1]  = bus_b.out_req_msg;
    assign o_qv[1]  = bus_b.out_req_val;
    assign o_cnt[1] = cnt_b;
    assign o_err[1] = err_b;

    // Reference model: tag list in issue order, rotating pointer, sticky error.
    int rr    [2];
    int tags  [2][MAXO];
    int cnt   [2];
    bit err_m [2];

    function automatic int nports(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int grant(input logic [MAXP-1:0] v, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        int n, g, gs;
        bit full, fire;
        logic [MAXP-1:0] v, e_rdy, e_rv;
        logic [MAXP*RESP_SZ-1:0] e_rm;
        string tag;
        for (int d = 0; d < 2; d++) begin
            n   = nports(d);
            tag = (d == 0) ? "A" : "B";
            if (!rst_n) begin
                chk({tag, " rst out_req_val"}, o_qv[d], 0);
                chk({tag, " rst in_req_rdy"}, o_rdy[d], 0);
                chk({tag, " rst in_resp_val"}, o_rv[d], 0);
                chk({tag, " rst outstanding"}, o_cnt[d], 0);
                chk({tag, " rst err"}, o_err[d], 0);
                rr[d]    = 0;
                cnt[d]   = 0;
                err_m[d] = 1'b0;
            end else begin
                v = '0;
                for (int p = 0; p < n; p++) v[p] = rval[d][p];
                full  = (cnt[d] == MAXO);
                g     = grant(v, n, (d == 0) ? rr[d] : 0);
                gs    = (g < 0) ? 0 : g;
                fire  = (g >= 0) && !full && ordy[d];
                e_rdy = '0;
                if (fire) e_rdy[gs] = 1'b1;
                e_rv = '0;
                if (rspv[d] && cnt[d] > 0) e_rv[tags[d][0]] = 1'b1;
                e_rm = '0;
                for (int p = 0; p < n; p++) e_rm[p*RESP_SZ +: RESP_SZ] = rspm[d];
                chk({tag, " out_req_val"}, o_qv[d], (g >= 0) && !full);
                chk({tag, " out_req_msg"}, o_qm[d], rmsg[d][gs*REQ_SZ +: REQ_SZ]);
                chk({tag, " in_req_rdy"}, o_rdy[d], e_rdy);
                chk({tag, " in_resp_val"}, o_rv[d], e_rv);
                chk({tag, " in_resp_msg"}, o_rm[d], e_rm);
                chk({tag, " outstanding"}, o_cnt[d], cnt[d]);
                chk({tag, " err_orphan"}, o_err[d], err_m[d]);
                // Advance to the state after the coming rising edge.
                if (rspv[d]) begin
                    if (cnt[d] > 0) begin
                        for (int k = 0; k < MAXO - 1; k++) tags[d][k] = tags[d][k + 1];
                        cnt[d]--;
                    end else begin
                        err_m[d] = 1'b1;
                    end
                end
                if (fire) begin
                    tags[d][cnt[d]] = gs;
                    cnt[d]++;
                    if (d == 0) rr[d] = (gs + 1) % n;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic [223:0] wide;
        logic [2:0] exp_rv [4];
        exp_rv = '{3'b010, 3'b001, 3'b010, 3'b001};
        for (int d = 0; d < 2; d++) begin
            rmsg[d] = '0; rval[d] = '0; ordy[d] = 1'b0; rspv[d] = 1'b0; rspm[d] = '0;
            rr[d] = 0; cnt[d] = 0; err_m[d] = 1'b0;
            for (int k = 0; k < MAXO; k++) tags[d][k] = 0;
        end
        // Round-robin alternation, fill to full, resume after one response.
        rmsg[0][0*REQ_SZ +: REQ_SZ] = {3'b0, 32'h100, 32'h0};
        rmsg[0][1*REQ_SZ +: REQ_SZ] = {3'b0, 32'h200, 32'h0};
        rval[0] = 3'b011;
        ordy[0] = 1'b1;
        tick();
        at_neg();
        chk("reset gates out_req_val", o_qv[0], 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("rr grant order", o_rdy[0], (i % 2 == 0) ? 3'b001 : 3'b010);
            chk("rr grant addr", o_qm[0][63:32], (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
        end
        at_neg();
        chk("full out_req_val", o_qv[0], 0);
        chk("full in_req_rdy", o_rdy[0], 0);
        chk("full outstanding", o_cnt[0], 4);
        tick();
        rspv[0] = 1'b1;
        rspm[0] = 35'hA;
        at_neg();
        chk("first resp to port0", o_rv[0], 3'b001);
        chk("first resp data", o_rm[0][RESP_SZ-1:0], 35'hA);
        chk("full despite pop", o_qv[0], 0);
        tick();
        rspv[0] = 1'b0;
        at_neg();
        chk("after pop outstanding", o_cnt[0], 3);
        chk("issue resumes", o_rdy[0], 3'b001);
        tick();
        rval[0] = '0;
        for (int j = 0; j < 4; j++) begin
            rspv[0] = 1'b1;
            rspm[0] = 35'(32'hB + j);
            at_neg();
            chk("resp routing order", o_rv[0], exp_rv[j]);
            tick();
        end
        rspv[0] = 1'b0;
        at_neg();
        chk("drained outstanding", o_cnt[0], 0);
        // Simultaneous fire and pop holding occupancy at 2 across pointer wraps.
        tick();
        rval[0] = 3'b011;
        tick();
        tick();
        rspv[0] = 1'b1;
        repeat (10) tick();
        rspv[0] = 1'b0;
        rval[0] = '0;
        at_neg();
        chk("fire+pop outstanding", o_cnt[0], 2);
        // Stalled grant does not rotate.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rval[0] = 3'b011;
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("stall rdy low", o_rdy[0], 0);
            chk("stall msg port0", o_qm[0][63:32], 32'h100);
            tick();
        end
        ordy[0] = 1'b1;
        at_neg();
        chk("after stall port0", o_rdy[0], 3'b001);
        tick();
        at_neg();
        chk("after stall port1", o_rdy[0], 3'b010);
        tick();
        // Reset with 3 outstanding, then an orphan response.
        rval[0] = 3'b001;
        tick();
        rval[0] = '0;
        at_neg();
        chk("three outstanding", o_cnt[0], 3);
        tick();
        rst_n = 1'b0;
        at_neg();
        chk("async reset clears count", o_cnt[0], 0);
        tick();
        rst_n = 1'b1;
        rspv[0] = 1'b1;
        at_neg();
        chk("orphan not delivered", o_rv[0], 0);
        tick();
        rspv[0] = 1'b0;
        at_neg();
        chk("orphan flag set", o_err[0], 1);
        chk("orphan outstanding", o_cnt[0], 0);
        // Fixed priority: port 0 starves port 2 until it drops.
        tick();
        rval[1] = 3'b101;
        ordy[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("fixed prio port0", o_rdy[1], 3'b001);
            tick();
        end
        rval[1] = 3'b100;
        at_neg();
        chk("fixed prio port2", o_rdy[1], 3'b100);
        tick();
        rval[1] = '0;
        rspv[1] = 1'b1;
        repeat (4) tick();
        rspv[1] = 1'b0;
        at_neg();
        chk("fixed prio drained", o_cnt[1], 0);
        tick();
        // Random traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int d = 0; d < 2; d++) begin
                for (int w = 0; w < 7; w++) wide[w*32 +: 32] = $urandom;
                rmsg[d] = wide[MAXP*REQ_SZ-1:0];
                rval[d] = 3'($urandom) & ((d == 0) ? 3'b011 : 3'b111);
                ordy[d] = ($urandom_range(0, 3) != 0);
                rspv[d] = (cnt[d] > 0) ? ($urandom_range(0, 1) == 1)
                                       : ($urandom_range(0, 63) == 0);
                rspm[d] = {3'($urandom), 32'($urandom)};
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
